// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate unit with a start/done handshake.
// Moves the operand by at most STEP bit positions per BUSY cycle, so an
// operation of effective count n_eff takes ceil(n_eff/STEP) cycles.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] amount,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] M_SHL  = 3'd0;
    localparam logic [2:0] M_SHR  = 3'd1;
    localparam logic [2:0] M_SHRA = 3'd2;
    localparam logic [2:0] M_ROL  = 3'd3;
    localparam logic [2:0] M_ROR  = 3'd4;

    // Counts live in AMT_W+1 bits so the full-width shift count WIDTH fits.
    localparam logic [AMT_W:0] WIDTH_A = (AMT_W+1)'(WIDTH);
    localparam logic [AMT_W:0] STEP_A  = (AMT_W+1)'(STEP);

    state_t           state_q;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] work_q;
    logic [AMT_W:0]   remain_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic             busy_q;
    logic             zero_q;

    logic [AMT_W:0]   n_eff_d;
    logic [AMT_W:0]   k_s;
    logic [AMT_W:0]   inv_s;
    logic [WIDTH-1:0] work_d;
    logic [AMT_W:0]   remain_d;

    // Effective count for a new request: rotates wrap modulo WIDTH, shifts
    // saturate at WIDTH (any bit at or above AMT_W means amount >= WIDTH).
    always_comb begin
        n_eff_d = '0;
        case (mode)
            M_ROL, M_ROR: begin
                n_eff_d = {1'b0, amount[AMT_W-1:0]};
            end
            M_SHL, M_SHR, M_SHRA: begin
                if (|amount[WIDTH-1:AMT_W]) begin
                    n_eff_d = WIDTH_A;
                end else begin
                    n_eff_d = {1'b0, amount[AMT_W-1:0]};
                end
            end
            default: begin
                n_eff_d = '0;
            end
        endcase
    end

    // One BUSY step: move the work register by k = min(STEP, remaining).
    // SHRA keeps the latched MSB in place, so >>> refills with that sign.
    always_comb begin
        if (remain_q < STEP_A) begin
            k_s = remain_q;
        end else begin
            k_s = STEP_A;
        end
        inv_s    = WIDTH_A - k_s;
        remain_d = remain_q - k_s;
        work_d   = work_q;
        case (mode_q)
            M_SHL:   work_d = work_q << k_s;
            M_SHR:   work_d = work_q >> k_s;
            M_SHRA:  work_d = $signed(work_q) >>> k_s;
            M_ROL:   work_d = (work_q << k_s) | (work_q >> inv_s);
            M_ROR:   work_d = (work_q >> k_s) | (work_q << inv_s);
            default: work_d = work_q;
        endcase
    end

    // Control FSM with registered outputs; clear overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            mode_q   <= 3'd0;
            work_q   <= '0;
            remain_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        mode_q   <= mode;
                        work_q   <= operand;
                        remain_q <= n_eff_d;
                        if (n_eff_d == '0) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= operand;
                            zero_q   <= (operand == '0);
                        end else begin
                            state_q <= ST_BUSY;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    work_q   <= work_d;
                    remain_q <= remain_d;
                    if (remain_d == '0) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        result_q <= work_d;
                        zero_q   <= (work_d == '0);
                    end else begin
                        state_q <= ST_BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: one STEP=1 and one STEP=4 instance.
module tb_seq_shifter;

    localparam logic [2:0] SHL = 3'd0, SHR = 3'd1, SHRA = 3'd2, ROL = 3'd3, ROR = 3'd4, PASS = 3'd7;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start1 = 1'b0, start4 = 1'b0;
    logic [2:0]  mode1 = 3'd0, mode4 = 3'd0;
    logic [31:0] op1 = 32'd0, op4 = 32'd0, amt1 = 32'd0, amt4 = 32'd0;
    logic [31:0] res1, res4;
    logic        done1, busy1, zero1, done4, busy4, zero4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          c;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    seq_shifter #(.WIDTH(32), .AMT_W(5), .STEP(1)) u_dut1 (
        .clock(clock), .clear(clear), .start(start1), .mode(mode1),
        .operand(op1), .amount(amt1), .result(res1), .done(done1),
        .busy(busy1), .zero(zero1)
    );

    seq_shifter #(.WIDTH(32), .AMT_W(5), .STEP(4)) u_dut4 (
        .clock(clock), .clear(clear), .start(start4), .mode(mode4),
        .operand(op4), .amount(amt4), .result(res4), .done(done4),
        .busy(busy4), .zero(zero4)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor for the STEP=1 instance: every done pulse must match the queue head.
    always @(negedge clock) begin : mon1
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done1: got done=1 expected no done (result %0h)", res1);
            end else begin
                e = q1.pop_front();
                check("res1", res1, e.res);
                check("zero1", zero1, e.z);
                check("done_cycle1", cyc, e.c);
            end
        end
    end

    // Monitor for the STEP=4 instance.
    always @(negedge clock) begin : mon4
        exp_t e;
        if (done4) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done4: got done=1 expected no done (result %0h)", res4);
            end else begin
                e = q4.pop_front();
                check("res4", res4, e.res);
                check("zero4", zero4, e.z);
                check("done_cycle4", cyc, e.c);
            end
        end
    end

    // Issue one op on the STEP=1 DUT from a negedge and wait for its done.
    task automatic run1(input string nm, input logic [2:0] m, input logic [31:0] op,
                        input logic [31:0] amt, input logic [31:0] expv, input int lat);
        int cnt = 0;
        bit seen = 1'b0;
        mode1 = m; op1 = op; amt1 = amt; start1 = 1'b1;
        q1.push_back('{expv, (expv == 32'd0), cyc + 1 + lat});
        for (int i = 0; i < lat + 8 && !seen; i++) begin
            @(negedge clock);
            start1 = 1'b0;
            if (busy1) cnt++;
            if (done1) seen = 1'b1;
        end
        check({nm, "_done_seen"}, seen, 1'b1);
        check({nm, "_busy_cycles"}, cnt, lat);
    endtask

    // Same for the STEP=4 DUT.
    task automatic run4(input string nm, input logic [2:0] m, input logic [31:0] op,
                        input logic [31:0] amt, input logic [31:0] expv, input int lat);
        int cnt = 0;
        bit seen = 1'b0;
        mode4 = m; op4 = op; amt4 = amt; start4 = 1'b1;
        q4.push_back('{expv, (expv == 32'd0), cyc + 1 + lat});
        for (int i = 0; i < lat + 8 && !seen; i++) begin
            @(negedge clock);
            start4 = 1'b0;
            if (busy4) cnt++;
            if (done4) seen = 1'b1;
        end
        check({nm, "_done_seen"}, seen, 1'b1);
        check({nm, "_busy_cycles"}, cnt, lat);
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clock);
        clear = 1'b0;

        // Reset state
        check("rst_result1", res1, 32'd0);
        check("rst_done1", done1, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_zero1", zero1, 1'b1);
        check("rst_result4", res4, 32'd0);
        check("rst_zero4", zero4, 1'b1);

        @(negedge clock);
        run1("rol1", ROL, 32'h8000_0001, 32'd1, 32'h0000_0003, 1);
        @(negedge clock);
        run1("shra40", SHRA, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 32);
        @(negedge clock);
        run1("shr40", SHR, 32'h8000_0000, 32'd40, 32'h0000_0000, 32);
        @(negedge clock);
        run1("shl0", SHL, 32'h1234_5678, 32'd0, 32'h1234_5678, 0);
        @(negedge clock);
        run1("pass7", PASS, 32'h1234_5678, 32'd7, 32'h1234_5678, 0);
        @(negedge clock);
        run1("shl5", SHL, 32'h0000_00F1, 32'd5, 32'h0000_1E20, 5);

        // Handshake: start during BUSY is ignored, start during DONE is taken.
        @(negedge clock);
        mode1 = SHL; op1 = 32'h0000_0001; amt1 = 32'd3; start1 = 1'b1;
        q1.push_back('{32'h0000_0008, 1'b0, cyc + 4});
        @(negedge clock);
        check("hs_busy", busy1, 1'b1);
        mode1 = ROR; op1 = 32'hFFFF_0000; amt1 = 32'd1; start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (done1) seen = 1'b1;
            else @(negedge clock);
        end
        check("hs_first_done", seen, 1'b1);
        run1("hs_second", ROR, 32'h0000_0001, 32'd1, 32'h8000_0000, 1);

        // Clear mid-operation: no done pulse, outputs back to reset values.
        @(negedge clock);
        mode1 = ROL; op1 = 32'h0000_0001; amt1 = 32'd20; start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        repeat (4) @(negedge clock);
        check("mid_busy", busy1, 1'b1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clr_result", res1, 32'd0);
        check("clr_busy", busy1, 1'b0);
        check("clr_done", done1, 1'b0);
        check("clr_zero", zero1, 1'b1);

        // Simultaneous start and clear: start is dropped.
        mode1 = ROL; op1 = 32'h0000_0001; amt1 = 32'd1; start1 = 1'b1; clear = 1'b1;
        @(negedge clock);
        start1 = 1'b0; clear = 1'b0;
        @(negedge clock);
        check("sc_busy", busy1, 1'b0);
        check("sc_result", res1, 32'd0);
        run1("rol20", ROL, 32'h0000_0001, 32'd20, 32'h0010_0000, 20);

        // STEP=4 instance
        @(negedge clock);
        run4("ror4", ROR, 32'h0000_000F, 32'd4, 32'hF000_0000, 1);
        @(negedge clock);
        run4("ror36", ROR, 32'h0000_000F, 32'd36, 32'hF000_0000, 1);
        @(negedge clock);
        run4("rol5", ROL, 32'h0000_0001, 32'd5, 32'h0000_0020, 2);
        @(negedge clock);
        run4("shl33", SHL, 32'h0000_0001, 32'd33, 32'h0000_0000, 8);
        @(negedge clock);
        run4("shra32", SHRA, 32'h8000_0000, 32'd32, 32'hFFFF_FFFF, 8);
        @(negedge clock);
        run4("shra3", SHRA, 32'h8000_0010, 32'd3, 32'hF000_0002, 1);

        repeat (4) @(negedge clock);
        check("q1_drained", q1.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
